// File: rtl/mgmt_mem_pkg.sv
// Shared constants and helpers for the management SoC memory path.
// Holds the default geometry, byte-lane derivation and per-channel slice math.
package mgmt_mem_pkg;

    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_AW = 8;

    function automatic int nb_of(input int dw);
        return dw / 8;
    endfunction

    // Low bit of channel idx inside a flattened per-channel bus of the given width.
    function automatic int ro_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mgmt_rr_arbiter.sv
// Combinational N-way round-robin pick: first request at or after ptr wins.
// The pointer register lives in the parent.
module mgmt_rr_arbiter
    import mgmt_mem_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    // Scan from the farthest slot back to ptr so the closest request is written last.
    always_comb begin
        int idx;
        logic [PW-1:0] sel;
        grant    = '0;
        next_ptr = ptr;
        idx      = 0;
        sel      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/mgmt_dffram_arbiter.sv
// Shares the single-port DFFRAM between the CPU port and N_RO read-only requestors.
// CPU has priority, RO channels are round-robin, and a stall counter forces RO progress.
module mgmt_dffram_arbiter
    import mgmt_mem_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int AW        = DEFAULT_AW,
    parameter int N_RO      = 2,
    parameter int MAX_STALL = 4,
    localparam int NB       = nb_of(DW)
) (
    input  logic                 core_clk,
    input  logic                 core_rst,
    input  logic                 cpu_en,
    input  logic [NB-1:0]        cpu_we,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic                 cpu_stall,
    output logic                 cpu_rvalid,
    output logic [DW-1:0]        cpu_rdata,
    input  logic [N_RO-1:0]      ro_req,
    input  logic [N_RO*AW-1:0]   ro_addr,
    output logic [N_RO-1:0]      ro_ack,
    output logic [N_RO*DW-1:0]   ro_data,
    output logic                 mem_en,
    output logic [NB-1:0]        mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_di,
    input  logic [DW-1:0]        mem_do
);

    localparam int PW  = ptr_w(N_RO);
    localparam int SCW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [SCW-1:0] STALL_SAT = SCW'(MAX_STALL);

    logic [N_RO-1:0] inflight_reg;
    logic [N_RO-1:0] s1_grant_reg;
    logic [N_RO-1:0] ro_ack_reg;
    logic [PW-1:0]   rr_ptr_reg;
    logic [SCW-1:0]  stall_cnt_reg;
    logic            cpu_rvalid_reg;
    logic [DW-1:0]   ro_data_reg [N_RO];

    logic [N_RO-1:0] eligible;
    logic [N_RO-1:0] arb_grant;
    logic [N_RO-1:0] ro_grant;
    logic [PW-1:0]   arb_next_ptr;
    logic [AW-1:0]   ro_addr_masked [N_RO];
    logic [AW-1:0]   ro_addr_sel;
    logic            any_eligible;
    logic            starve;
    logic            cpu_win;
    logic            ro_win;

    assign eligible     = ro_req & ~inflight_reg;
    assign any_eligible = |eligible;
    assign starve       = (MAX_STALL != 0) && (stall_cnt_reg >= STALL_SAT);

    // Outputs are forced quiet while reset is held so the RAM sees no stray access.
    assign cpu_win   = cpu_en & ~core_rst & (~any_eligible | ~starve);
    assign ro_win    = ~core_rst & ~cpu_win & any_eligible;
    assign ro_grant  = ro_win ? arb_grant : '0;
    assign cpu_stall = cpu_en & ~core_rst & ~cpu_win;

    mgmt_rr_arbiter #(
        .N(N_RO)
    ) u_rr (
        .req      (eligible),
        .ptr      (rr_ptr_reg),
        .grant    (arb_grant),
        .next_ptr (arb_next_ptr)
    );

    generate
        for (genvar gi = 0; gi < N_RO; gi++) begin : g_ch
            assign ro_addr_masked[gi] = ro_grant[gi] ? ro_addr[ro_lsb(gi, AW) +: AW] : '0;
            assign ro_data[ro_lsb(gi, DW) +: DW] = ro_data_reg[gi];

            always_ff @(posedge core_clk or posedge core_rst) begin
                if (core_rst) begin
                    ro_data_reg[gi] <= '0;
                end else if (s1_grant_reg[gi]) begin
                    ro_data_reg[gi] <= mem_do;
                end
            end
        end
    endgenerate

    always_comb begin
        ro_addr_sel = '0;
        for (int i = 0; i < N_RO; i++) begin
            ro_addr_sel = ro_addr_sel | ro_addr_masked[i];
        end
    end

    assign mem_en   = cpu_win | ro_win;
    assign mem_we   = cpu_win ? cpu_we : '0;
    assign mem_addr = cpu_win ? cpu_addr : ro_addr_sel;
    assign mem_di   = cpu_win ? cpu_wdata : '0;

    assign cpu_rvalid = cpu_rvalid_reg;
    assign cpu_rdata  = mem_do;
    assign ro_ack     = ro_ack_reg;

    // inflight stays set through the ack cycle, so a held request re-arbitrates only after it.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            inflight_reg   <= '0;
            s1_grant_reg   <= '0;
            ro_ack_reg     <= '0;
            rr_ptr_reg     <= '0;
            stall_cnt_reg  <= '0;
            cpu_rvalid_reg <= 1'b0;
        end else begin
            inflight_reg   <= (inflight_reg | ro_grant) & ~ro_ack_reg;
            s1_grant_reg   <= ro_grant;
            ro_ack_reg     <= s1_grant_reg;
            cpu_rvalid_reg <= cpu_win & ~(|cpu_we);
            if (ro_win) begin
                rr_ptr_reg    <= arb_next_ptr;
                stall_cnt_reg <= '0;
            end else if (cpu_win && any_eligible && (stall_cnt_reg != STALL_SAT)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mgmt_dffram_arbiter.sv
// Directed bench for mgmt_dffram_arbiter with a behavioural single-port RAM model.
module tb_mgmt_dffram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NB = DW / 8;
    localparam int N_RO = 2;

    logic                 clk;
    logic                 rst;
    logic                 cpu_en;
    logic [NB-1:0]        cpu_we;
    logic [AW-1:0]        cpu_addr;
    logic [DW-1:0]        cpu_wdata;
    logic                 cpu_stall;
    logic                 cpu_rvalid;
    logic [DW-1:0]        cpu_rdata;
    logic [N_RO-1:0]      ro_req;
    logic [N_RO*AW-1:0]   ro_addr;
    logic [N_RO-1:0]      ro_ack;
    logic [N_RO*DW-1:0]   ro_data;
    logic                 mem_en;
    logic [NB-1:0]        mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_di;
    logic [DW-1:0]        mem_do = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    mgmt_dffram_arbiter #(
        .DW(DW), .AW(AW), .N_RO(N_RO), .MAX_STALL(4)
    ) dut (
        .core_clk   (clk),
        .core_rst   (rst),
        .cpu_en     (cpu_en),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ro_req     (ro_req),
        .ro_addr    (ro_addr),
        .ro_ack     (ro_ack),
        .ro_data    (ro_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .mem_do     (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_di[b*8 +: 8];
            end
            mem_do <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_en = 1'b1; cpu_we = '1; cpu_addr = a; cpu_wdata = d;
        #2;
        chk("wr_stall", cpu_stall, 1'b0);
        chk("wr_mem_di", mem_di, d);
        tick;
        cpu_en = 1'b0; cpu_we = '0;
    endtask

    initial begin
        int ph;
        logic [1:0] exp_ack;
        rst = 1'b1; cpu_en = 0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        ro_req = '0; ro_addr = '0;

        // 1. reset and idle
        #1;
        chk("rst_ro_data", ro_data, 64'h0);
        tick; tick;
        chk("rst_ro_ack", ro_ack, 2'b00);
        chk("rst_rvalid", cpu_rvalid, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 4'h0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_di", mem_di, 32'h0);
        chk("rst_stall", cpu_stall, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("idle_mem_en", mem_en, 1'b0);
            chk("idle_ro_ack", ro_ack, 2'b00);
            chk("idle_rvalid", cpu_rvalid, 1'b0);
            tick;
        end

        // 2. CPU write then read back
        cpu_en = 1; cpu_we = 4'hF; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
        #2;
        chk("t2_stall_w", cpu_stall, 1'b0);
        chk("t2_mem_en_w", mem_en, 1'b1);
        chk("t2_mem_we_w", mem_we, 4'hF);
        chk("t2_mem_addr_w", mem_addr, 8'h10);
        chk("t2_mem_di_w", mem_di, 32'hDEADBEEF);
        tick;
        cpu_we = 4'h0;
        #2;
        chk("t2_stall_r", cpu_stall, 1'b0);
        chk("t2_mem_we_r", mem_we, 4'h0);
        chk("t2_no_wr_rvalid", cpu_rvalid, 1'b0);
        tick;
        cpu_en = 0;
        #2;
        chk("t2_rvalid", cpu_rvalid, 1'b1);
        chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
        tick;
        #2;
        chk("t2_rvalid_off", cpu_rvalid, 1'b0);

        // 3. two RO reads back to back
        cpu_write(8'h20, 32'h11111111);
        cpu_write(8'h21, 32'h22222222);
        ro_req = 2'b11; ro_addr = {8'h21, 8'h20};
        #2;
        chk("t3_g0_en", mem_en, 1'b1);
        chk("t3_g0_we", mem_we, 4'h0);
        chk("t3_g0_addr", mem_addr, 8'h20);
        tick;
        #2;
        chk("t3_g1_addr", mem_addr, 8'h21);
        chk("t3_g1_ack", ro_ack, 2'b00);
        tick;
        ro_req = 2'b10;
        #2;
        chk("t3_ack0", ro_ack, 2'b01);
        chk("t3_data0", ro_data[31:0], 32'h11111111);
        chk("t3_idle_en", mem_en, 1'b0);
        tick;
        ro_req = 2'b00;
        #2;
        chk("t3_ack1", ro_ack, 2'b10);
        chk("t3_data1", ro_data[63:32], 32'h22222222);
        chk("t3_data0_hold", ro_data[31:0], 32'h11111111);
        tick;
        #2;
        chk("t3_ack_off", ro_ack, 2'b00);
        tick;

        // 5. round-robin fairness: grant pattern 0,1,idle repeating
        ro_req = 2'b11; ro_addr = {8'h21, 8'h20};
        for (int i = 0; i < 9; i++) begin
            #2;
            ph = i % 3;
            chk("t5_en", mem_en, ph != 2);
            if (ph != 2) chk("t5_addr", mem_addr, (ph == 0) ? 8'h20 : 8'h21);
            exp_ack = (ph == 2) ? 2'b01 : ((ph == 0 && i > 0) ? 2'b10 : 2'b00);
            chk("t5_ack", ro_ack, exp_ack);
            tick;
        end
        ro_req = 2'b00;
        #2;
        chk("t5_last_ack", ro_ack, 2'b10);
        chk("t5_last_en", mem_en, 1'b0);
        chk("t5_data", ro_data, {32'h22222222, 32'h11111111});
        tick;

        // 4. starvation, run twice to show the counter restarts from zero
        cpu_en = 1; cpu_we = 4'h0; cpu_addr = 8'h20; ro_addr = {8'h21, 8'h10};
        for (int r = 0; r < 2; r++) begin
            ro_req = 2'b01;
            for (int k = 0; k < 4; k++) begin
                #2;
                chk("t4_cpu_stall", cpu_stall, 1'b0);
                chk("t4_cpu_addr", mem_addr, 8'h20);
                tick;
            end
            #2;
            chk("t4_forced_stall", cpu_stall, 1'b1);
            chk("t4_ro_addr", mem_addr, 8'h10);
            chk("t4_ro_we", mem_we, 4'h0);
            chk("t4_rvalid_prev", cpu_rvalid, 1'b1);
            chk("t4_rdata_prev", cpu_rdata, 32'h11111111);
            tick;
            #2;
            chk("t4_after_stall", cpu_stall, 1'b0);
            chk("t4_after_addr", mem_addr, 8'h20);
            chk("t4_no_rvalid", cpu_rvalid, 1'b0);
            chk("t4_no_ack_yet", ro_ack, 2'b00);
            tick;
            ro_req = 2'b00;
            #2;
            chk("t4_ack", ro_ack, 2'b01);
            chk("t4_data", ro_data[31:0], 32'hDEADBEEF);
            chk("t4_rvalid", cpu_rvalid, 1'b1);
            chk("t4_ack_stall", cpu_stall, 1'b0);
            tick;
        end
        cpu_en = 0;
        tick;

        // 6. reset in the cycle after an RO grant
        ro_req = 2'b01; ro_addr = {8'h20, 8'h21};
        #2;
        chk("t6_grant_en", mem_en, 1'b1);
        chk("t6_grant_addr", mem_addr, 8'h21);
        tick;
        rst = 1'b1; ro_req = 2'b00;
        #2;
        chk("t6_rst_data", ro_data, 64'h0);
        chk("t6_rst_ack", ro_ack, 2'b00);
        chk("t6_rst_en", mem_en, 1'b0);
        tick;
        rst = 1'b0;
        #2;
        chk("t6_no_ack", ro_ack, 2'b00);
        chk("t6_data_zero", ro_data, 64'h0);
        tick;
        ro_req = 2'b01;
        #2;
        chk("t6_reissue_en", mem_en, 1'b1);
        chk("t6_reissue_addr", mem_addr, 8'h21);
        tick;
        #2;
        chk("t6_wait_ack", ro_ack, 2'b00);
        tick;
        ro_req = 2'b00;
        #2;
        chk("t6_ack", ro_ack, 2'b01);
        chk("t6_data", ro_data[31:0], 32'h22222222);
        tick;
        #2;
        chk("t6_ack_off", ro_ack, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mgmt_dffram_arbiter.md
Name: mgmt_dffram_arbiter

Overview:
Parametrised arbiter in front of the management SoC single-port DFFRAM.
It shares the RAM between one CPU read/write port and N_RO independent read-only requestors (housekeeping, debug, future DMA).
The CPU port has priority, the read-only channels are served round-robin, and a starvation counter guarantees read-only progress.
It sits between mgmt_core and the DFFRAM macro and replaces the single fixed read-only access path.

Parameters:
DW, 32, data width in bits; must be a multiple of 8.
AW, 8, word address width; RAM depth is 2^AW words.
N_RO, 2, number of read-only channels (1..8).
MAX_STALL, 4, consecutive CPU-won cycles with read-only requests pending before a read-only channel is forced through; 0 disables this (CPU has absolute priority).
Localparam NB = DW/8, the byte-lane count.

Ports:
core_clk  in  1  single clock.
core_rst  in  1  asynchronous reset, active-high.
cpu_en  in  1  CPU access request; held until not stalled.
cpu_we  in  NB  byte write enables; 0 means read.
cpu_addr  in  AW  CPU word address.
cpu_wdata  in  DW  CPU write data.
cpu_stall  out  1  combinational; CPU request not taken this cycle.
cpu_rvalid  out  1  CPU read data valid.
cpu_rdata  out  DW  CPU read data (mem_do passthrough).
ro_req  in  N_RO  per-channel read request (level).
ro_addr  in  N_RO*AW  per-channel address; channel i occupies bits [i*AW +: AW].
ro_ack  out  N_RO  one-cycle pulse when ro_data[i] is updated.
ro_data  out  N_RO*DW  per-channel registered read data, held between acks.
mem_en  out  1  RAM enable.
mem_we  out  NB  RAM byte write enables.
mem_addr  out  AW  RAM address.
mem_di  out  DW  RAM write data.
mem_do  in  DW  RAM read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset values. On reset all outputs are 0:
  - ro_data, ro_ack, cpu_rvalid and the mem_* outputs are 0.
  - The rr pointer is 0, stall_cnt is 0 and all in-flight flags are cleared.
- Slot assignment. Each cycle exactly one slot is given: CPU, one RO channel, or idle (mem_en=0).
- Eligibility. RO channel i is eligible when ro_req[i]=1 and inflight[i]=0.
- CPU wins when cpu_en=1 and (no RO channel is eligible, or MAX_STALL=0, or stall_cnt<MAX_STALL).
- Otherwise the eligible channel first at or after the rr pointer wins:
  - The rr pointer moves to winner+1, mod N_RO.
  - inflight[winner] is set.
- cpu_stall = cpu_en & ~cpu_win.
- stall_cnt:
  - Increments, saturating at MAX_STALL, on each cycle where CPU wins while any RO channel is eligible.
  - Clears on any RO grant.
  - Holds otherwise.
- CPU read granted in cycle t:
  - cpu_rvalid=1 in t+1.
  - cpu_rdata = mem_do in t+1.
- CPU write granted in cycle t:
  - mem_we=cpu_we and mem_di=cpu_wdata in t.
  - No rvalid is produced.
- RO grant in cycle t:
  - mem_en=1, mem_we=0, mem_addr=ro_addr[i] in t.
  - ro_data[i] is captured from mem_do at the end of t+1.
  - ro_ack[i]=1 in t+2; inflight[i] clears in that same cycle.
  - Latency is 2.
- RO protocol:
  - The requestor holds ro_req and ro_addr until ro_ack.
  - ro_req still high in the ack cycle is a new request, eligible from t+3 onward.
  - A request dropped after grant still completes and acks.
- Multiple RO channels may be in flight simultaneously, one grant per cycle; acks return in grant order.
- Same-address hazard. An RO read granted the cycle after a CPU write to the same address returns the new data; the RAM is write-first per cycle-ordered access.
- Reset mid-operation. In-flight reads are dropped with no ack; requestors must reissue.

Decomposition:
- Package mgmt_mem_pkg holds:
  - Default DW/AW constants.
  - The NB derivation.
  - An ro-channel slice helper (index i → bit range).
- Sub-module mgmt_rr_arbiter (N-way round-robin):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, next pointer.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. Reset then idle: all outputs 0, mem_en=0 for 10 cycles.
2. CPU write 0xDEADBEEF to address 0x10 with cpu_we=4'hF, then read it back: cpu_rvalid=1 one cycle after the read grant, cpu_rdata=0xDEADBEEF, cpu_stall never asserted.
3. Preload addresses 0x20/0x21 with 0x11111111/0x22222222. Assert ro_req=2'b11 (ch0 addr 0x20, ch1 addr 0x21) with the CPU idle. Required: ch0 granted in t, ch1 in t+1; ro_ack[0] in t+2 with data 0x11111111; ro_ack[1] in t+3 with data 0x22222222.
4. Starvation: cpu_en held high (reads) while ro_req[0]=1 with MAX_STALL=4. Required: the CPU wins 4 cycles, then cpu_stall=1 for exactly one cycle as ch0 is granted; ro_ack[0] follows 2 cycles later and stall_cnt returns to 0.
5. Round-robin fairness: both RO channels request continuously with the CPU idle. Grants alternate 0,1,0,1; each channel is re-granted no earlier than 3 cycles after its previous grant.
6. Assert core_rst in the cycle after an RO grant. Required: no ro_ack, ro_data=0, inflight cleared; the re-issued request completes normally after reset release.
